// File: rtl/mem_port_arbiter.sv
// Shared data-memory port arbiter: boot lock, fixed-priority or round-robin grant,
// and per-master read-return tagging for a fixed-latency memory.
module mem_port_arbiter #(
  parameter int NUM_MASTERS  = 2,
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MODE         = 0,
  parameter int READ_LATENCY = 1,
  parameter int BOOT_MASTER  = 0
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          boot_done,
  input  logic [NUM_MASTERS-1:0]        req,
  input  logic [NUM_MASTERS-1:0]        we,
  input  logic [NUM_MASTERS*ADDR_W-1:0] addr,
  input  logic [NUM_MASTERS*DATA_W-1:0] wdata,
  output logic [NUM_MASTERS-1:0]        gnt,
  output logic [NUM_MASTERS-1:0]        rvalid,
  output logic [DATA_W-1:0]             rdata,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          busy
);

  localparam int IDX_W = (NUM_MASTERS > 2) ? $clog2(NUM_MASTERS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  logic [NUM_MASTERS-1:0]  elig;
  logic                    lo_found, hi_found, any_gnt, we_sel;
  logic [IDX_W-1:0]        lo_idx, hi_idx, gnt_idx;
  logic [IDX_W-1:0]        ptr_d, ptr_q;
  logic [ADDR_W-1:0]       addr_sel, mem_addr_d, mem_addr_q;
  logic [DATA_W-1:0]       wdata_sel, mem_wdata_d, mem_wdata_q;
  logic [READ_LATENCY-1:0] vld_d, vld_q;
  logic [IDX_W-1:0]        tag_d [READ_LATENCY];
  logic [IDX_W-1:0]        tag_q [READ_LATENCY];

  // lo_* is the lowest eligible index, hi_* the lowest at or after the pointer;
  // falling back to lo_* gives the modulo wrap. MODE 0 keeps the pointer at 0.
  always_comb begin
    elig     = boot_done ? req : (req & (NUM_MASTERS'(1) << BOOT_MASTER));
    lo_found = 1'b0;
    hi_found = 1'b0;
    lo_idx   = '0;
    hi_idx   = '0;
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (elig[i]) begin
        lo_found = 1'b1;
        lo_idx   = IDX_W'(i);
        if (IDX_W'(i) >= ptr_q) begin
          hi_found = 1'b1;
          hi_idx   = IDX_W'(i);
        end
      end
    end
    any_gnt = reset && lo_found;
    gnt_idx = hi_found ? hi_idx : lo_idx;
    gnt     = any_gnt ? (NUM_MASTERS'(1) << gnt_idx) : '0;
  end

  always_comb begin
    addr_sel  = '0;
    wdata_sel = '0;
    we_sel    = 1'b0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (gnt[i]) begin
        addr_sel  = addr[i*ADDR_W +: ADDR_W];
        wdata_sel = wdata[i*DATA_W +: DATA_W];
        we_sel    = we[i];
      end
    end
    mem_addr_d  = any_gnt ? addr_sel : mem_addr_q;
    mem_wdata_d = any_gnt ? wdata_sel : mem_wdata_q;
    mem_addr    = reset ? mem_addr_d : '0;
    mem_wdata   = reset ? mem_wdata_d : '0;
    mem_we      = any_gnt & we_sel;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (MODE == 1 && any_gnt) begin
      ptr_d = (gnt_idx == LAST_IDX) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_comb begin
    vld_d    = '0;
    tag_d    = tag_q;
    vld_d[0] = any_gnt & ~we_sel;
    tag_d[0] = gnt_idx;
    for (int s = 1; s < READ_LATENCY; s++) begin
      vld_d[s] = vld_q[s-1];
      tag_d[s] = tag_q[s-1];
    end
  end

  assign rvalid = (reset && vld_q[READ_LATENCY-1]) ?
                  (NUM_MASTERS'(1) << tag_q[READ_LATENCY-1]) : '0;
  assign rdata  = mem_rdata;
  assign busy   = |vld_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q       <= '0;
      vld_q       <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int s = 0; s < READ_LATENCY; s++) tag_q[s] <= '0;
    end else begin
      ptr_q       <= ptr_d;
      vld_q       <= vld_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Parametrised arbiter for the shared data-memory port (port B). Generalises the two-way UART-loader/CPU select into NUM_MASTERS requesters.
- Supports a boot lock, fixed-priority or round-robin arbitration, and per-master read-return tracking for a memory with READ_LATENCY cycles of latency.
- Sits between the requesters (CPU data cache, UART loader, future DMA/VGA writer) and the Memory block port B.

Parameters:
- NUM_MASTERS, 2, number of requesters (2..8).
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MODE, 0, arbitration mode: 0 = fixed priority (lowest index wins), 1 = round-robin.
- READ_LATENCY, 1, cycles from grant to valid mem_rdata (1..4).
- BOOT_MASTER, 0, index of the only master serviced while boot_done=0.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- boot_done  in  1  0 = boot/programming phase, 1 = normal operation.
- req  in  NUM_MASTERS  per-master request; held until granted.
- we  in  NUM_MASTERS  per-master write enable; qualifies req.
- addr  in  NUM_MASTERS*ADDR_W  packed addresses; master i in slice [i*ADDR_W +: ADDR_W].
- wdata  in  NUM_MASTERS*DATA_W  packed write data.
- gnt  out  NUM_MASTERS  one-hot grant; high in the cycle the access is driven to memory.
- rvalid  out  NUM_MASTERS  one-hot read-return strobe.
- rdata  out  DATA_W  read data; broadcast, qualified by rvalid.
- mem_addr  out  ADDR_W  memory port address.
- mem_wdata  out  DATA_W  memory port write data.
- mem_we  out  1  memory port write enable.
- mem_rdata  in  DATA_W  memory port read data.
- busy  out  1  high while any read is in flight.

Behaviour:
- Reset (reset=0 sampled at a clk edge):
  - rr pointer ← 0; read-tracking pipeline cleared; busy=0.
  - While reset=0: gnt=0, rvalid=0, mem_we=0, mem_addr=0, mem_wdata=0.
- Eligibility:
  - boot_done=0: only req[BOOT_MASTER] is eligible; all other requests wait with gnt=0.
  - boot_done=1: all masters are eligible.
- Grant is combinational from eligible req and the current pointer, at most one access per cycle.
  - MODE 0: lowest eligible index wins.
  - MODE 1: first eligible index at or after the pointer, searching modulo NUM_MASTERS.
- Pointer update (MODE 1 only): at the clk edge after granting i, pointer ← (i+1) mod NUM_MASTERS. Unchanged when nothing is granted. In MODE 0 the pointer stays 0.
- Memory port:
  - With gnt[i]=1: mem_addr/mem_wdata = master i slices and mem_we = we[i].
  - With no grant: mem_we=0; mem_addr and mem_wdata hold their last driven values (registered copies), so the port stays stable.
- Handshake:
  - A master keeps req/we/addr/wdata stable until it samples gnt=1.
  - It may present its next request in the following cycle; back-to-back grants to the same master are allowed if it is the only requester.
- Read tracking:
  - Each granted read (we=0) enters a READ_LATENCY-deep shift register tagged with the master index.
  - READ_LATENCY cycles after the grant edge: rvalid[tag]=1 for exactly one cycle, with rdata=mem_rdata.
  - Writes produce no rvalid.
  - busy=1 when any shift stage is valid.
- Boundary conditions:
  - Simultaneous grant and return: a new read grant and an older return in the same cycle both proceed; no stall.
  - boot_done 1→0: in-flight reads still return; from the next arbitration only BOOT_MASTER is serviced.
  - boot_done 0→1: arbitration opens in the same cycle; the pointer is not reset.
  - req asserted to a non-eligible master: ignored, no side effects.
  - Reset mid-transaction: pending returns are discarded and no rvalid is emitted for them.
  - Pointer wrap: from NUM_MASTERS-1 to 0.

Test Plan:
- Reset/boot lock: reset=0 for 2 cycles, then boot_done=0, req=2'b11 with both masters writing (BOOT_MASTER=0) → gnt=01 every cycle, gnt[1]=0. Set boot_done=1 and drop req[0] → gnt=10 next cycle.
- Fixed priority (MODE=0, N=3): req=3'b110 held for 3 cycles → gnt=010 each cycle. Drop req[1] → gnt=100.
- Round-robin (MODE=1, N=3): req=3'b111 held for 6 cycles → gnt sequence 001,010,100,001,010,100.
- Read latency (READ_LATENCY=2): master 1 reads addr 0x10, memory model returns 0xDEADBEEF → rvalid=10 exactly 2 cycles after gnt, rdata=0xDEADBEEF; busy high for 2 cycles.
- Interleave: master 0 reads, then master 1 writes 0x55 to 0x20 on the next cycle → rvalid[0] only; mem_we=1 only in master 1's grant cycle.
- Reset mid-flight: grant a read, then assert reset=0 one cycle later → no rvalid; busy=0 after the reset edge.
